// File: rtl/pipeexe_md_if.sv
// Bundle of the EX-stage inputs from ID/EX and the stage outputs toward EX/MEM and the
// hazard unit. The master drives operands and control; the slave is the execute stage.
interface pipeexe_md_if #(
    parameter int WIDTH   = 32,
    parameter int RN_BITS = 5
);
    logic               evalid;
    logic [3:0]         ealuc;
    logic               ealuimm;
    logic               eshift;
    logic               ejal;
    logic [2:0]         emd_op;
    logic [WIDTH-1:0]   ea;
    logic [WIDTH-1:0]   eb;
    logic [WIDTH-1:0]   eimm;
    logic [WIDTH-1:0]   epc4;
    logic [RN_BITS-1:0] ern0;
    logic [WIDTH-1:0]   ealu;
    logic [RN_BITS-1:0] ern;
    logic               estall;
    logic               md_busy;

    modport master (
        output evalid, ealuc, ealuimm, eshift, ejal, emd_op, ea, eb, eimm, epc4, ern0,
        input  ealu, ern, estall, md_busy
    );

    modport slave (
        input  evalid, ealuc, ealuimm, eshift, ejal, emd_op, ea, eb, eimm, epc4, ern0,
        output ealu, ern, estall, md_busy
    );
endinterface

// File: rtl/pipeexe_md.sv
// Execute stage: single-cycle ALU/shift/jal paths plus an iterative radix-2
// multiply/divide unit with HI/LO registers that stalls the pipeline while it runs.
module pipeexe_md #(
    parameter int WIDTH   = 32,
    parameter int RN_BITS = 5
) (
    input logic         clock,
    input logic         reset,
    pipeexe_md_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMfhi  = 3'b101;
    localparam logic [2:0] OpMflo  = 3'b110;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] acc_q;    // product high half / partial remainder
    logic [WIDTH-1:0] wrk_q;    // multiplier bits / dividend bits, then low product / quotient
    logic [WIDTH-1:0] mcand_q;  // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_raw_q;  // original ea, returned as HI on divide by zero
    logic [CW-1:0]    cnt_q;
    logic             mul_q;
    logic             a_neg_q;
    logic             b_neg_q;

    // Operand selection and ALU
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] alua;
    logic [WIDTH-1:0] alub;
    logic [WIDTH-1:0] alu_res;

    assign sa   = {{(WIDTH - 5){1'b0}}, bus.eimm[10:6]};
    assign alua = bus.eshift ? sa : bus.ea;
    assign alub = bus.ealuimm ? bus.eimm : bus.eb;

    // ALU result; bit 3 of ealuc only separates srl from sra
    always_comb begin
        alu_res = '0;
        casez (bus.ealuc)
            4'b?000: alu_res = alua + alub;
            4'b?100: alu_res = alua - alub;
            4'b?001: alu_res = alua & alub;
            4'b?101: alu_res = alua | alub;
            4'b?010: alu_res = alua ^ alub;
            4'b?110: alu_res = alub << 16;
            4'b0011: alu_res = alub << alua[4:0];
            4'b0111: alu_res = alub >> alua[4:0];
            4'b1111: alu_res = $signed(alub) >>> alua[4:0];
            default: alu_res = '0;
        endcase
    end

    // Start decode: depends only on state, evalid and emd_op
    logic md_arith;
    logic signed_op;
    logic mul_op;
    logic start;

    assign md_arith  = (bus.emd_op == OpMult) || (bus.emd_op == OpMultu) ||
                       (bus.emd_op == OpDiv)  || (bus.emd_op == OpDivu);
    assign signed_op = (bus.emd_op == OpMult) || (bus.emd_op == OpDiv);
    assign mul_op    = (bus.emd_op == OpMult) || (bus.emd_op == OpMultu);
    assign start     = (state_q == StIdle) && bus.evalid && md_arith;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign a_neg = signed_op && bus.ea[WIDTH-1];
    assign b_neg = signed_op && bus.eb[WIDTH-1];
    assign mag_a = a_neg ? -bus.ea : bus.ea;
    assign mag_b = b_neg ? -bus.eb : bus.eb;

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;

    assign mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next  = {mul_sum, wrk_q[WIDTH-1:1]};
    assign div_shift = {acc_q, wrk_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        wrk_q[WIDTH-2:0], div_ok};

    // Sign correction and divide-by-zero override applied in DONE
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   hi_fin;
    logic [WIDTH-1:0]   lo_fin;

    assign prod     = {acc_q, wrk_q};
    assign prod_fin = (a_neg_q ^ b_neg_q) ? -prod : prod;

    // Final HI/LO values for the finishing operation
    always_comb begin
        hi_fin = '0;
        lo_fin = '0;
        if (mul_q) begin
            {hi_fin, lo_fin} = prod_fin;
        end else if (mcand_q == '0) begin
            hi_fin = a_raw_q;
            lo_fin = '1;
        end else begin
            lo_fin = (a_neg_q ^ b_neg_q) ? -wrk_q : wrk_q;
            hi_fin = a_neg_q ? -acc_q : acc_q;
        end
    end

    // Multiply/divide FSM with its datapath and HI/LO registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            mcand_q <= '0;
            a_raw_q <= '0;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= '0;
                        wrk_q   <= mag_a;
                        mcand_q <= mag_b;
                        a_raw_q <= bus.ea;
                        mul_q   <= mul_op;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    {acc_q, wrk_q} <= mul_q ? mul_next : div_next;
                    cnt_q          <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    hi_q    <= hi_fin;
                    lo_q    <= lo_fin;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ern     = bus.ern0 | {RN_BITS{bus.ejal}};
    assign bus.estall  = start || (state_q == StRun);
    assign bus.md_busy = (state_q != StIdle);

    // Stage result: jal return address, then HI/LO moves, then the ALU
    always_comb begin
        bus.ealu = alu_res;
        if (bus.ejal) begin
            bus.ealu = bus.epc4 + WIDTH'(4);
        end else if (bus.emd_op == OpMfhi) begin
            bus.ealu = hi_q;
        end else if (bus.emd_op == OpMflo) begin
            bus.ealu = lo_q;
        end
    end
endmodule

// File: tb/tb_pipeexe_md.sv
// Self-checking bench for pipeexe_md at WIDTH = 32: a table of combinational vectors,
// hand-written multiply/divide/reset sequences and randomized traffic against a
// plain-arithmetic reference model.
module tb_pipeexe_md;
    localparam int W = 32;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    logic clock;
    logic reset;

    pipeexe_md_if #(.WIDTH(W), .RN_BITS(5)) bus ();

    pipeexe_md #(.WIDTH(W), .RN_BITS(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef struct {
        logic [3:0] aluc;
        logic       aluimm;
        logic       shift;
        logic       jal;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic [W-1:0] pc4;
        logic [4:0] rn0;
        logic [W-1:0] exp_alu;
        logic [4:0] exp_rn;
    } vec_t;

    vec_t vecs [11];

    logic [3:0] alu_codes [9] = '{4'h0, 4'h4, 4'h1, 4'h5, 4'h2, 4'h6, 4'h3, 4'h7, 4'hF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic valid, input logic [3:0] aluc, input logic aluimm,
                          input logic shift, input logic jal, input logic [2:0] md,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic [W-1:0] pc4,
                          input logic [4:0] rn0);
        bus.evalid  = valid;
        bus.ealuc   = aluc;
        bus.ealuimm = aluimm;
        bus.eshift  = shift;
        bus.ejal    = jal;
        bus.emd_op  = md;
        bus.ea      = a;
        bus.eb      = b;
        bus.eimm    = imm;
        bus.epc4    = pc4;
        bus.ern0    = rn0;
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (c)
            4'h0, 4'h8: return a + b;
            4'h4, 4'hC: return a - b;
            4'h1, 4'h9: return a & b;
            4'h5, 4'hD: return a | b;
            4'h2, 4'hA: return a ^ b;
            4'h6, 4'hE: return {b[15:0], 16'h0000};
            4'h3:       return b << a[4:0];
            4'h7:       return b >> a[4:0];
            4'hF:       return $unsigned($signed(b) >>> a[4:0]);
            default:    return '0;
        endcase
    endfunction

    // HI/LO from ordinary 64-bit arithmetic
    task automatic ref_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        case (op)
            MD_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            MD_MULTU: begin p = 64'(ua * ub); hi = p[63:32]; lo = p[31:0]; end
            MD_DIV: begin
                if (b == '0) begin hi = a; lo = '1; end
                else begin
                    p  = 64'(sa / sb);
                    lo = p[31:0];
                    p  = 64'(sa % sb);
                    hi = p[31:0];
                end
            end
            MD_DIVU: begin
                if (b == '0) begin hi = a; lo = '1; end
                else begin
                    p  = ua / ub;
                    lo = p[31:0];
                    p  = ua % ub;
                    hi = p[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Issue one md op, count stall cycles, then read HI and LO back through mfhi/mflo
    task automatic run_md(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int n;
        @(negedge clock);
        set_in(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, op, a, b, '0, '0, 5'd0);
        #1;
        n = 0;
        while (bus.estall === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
            #1;
        end
        check({name, " stall_cycles"}, 64'(n), 64'd33);
        check({name, " busy_in_done"}, 64'(bus.md_busy), 64'd1);
        m_hi = exp_hi;
        m_lo = exp_lo;
        @(negedge clock);
        set_in(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, MD_MFHI, '0, '0, '0, '0, 5'd0);
        #1;
        check({name, " mfhi"}, 64'(bus.ealu), 64'(exp_hi));
        check({name, " idle_after"}, 64'(bus.md_busy), 64'd0);
        bus.emd_op = MD_MFLO;
        #1;
        check({name, " mflo"}, 64'(bus.ealu), 64'(exp_lo));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] ri;
        logic [W-1:0] rp;
        logic [W-1:0] exp_alu;
        logic [4:0]   rrn;
        logic [3:0]   rcode;
        logic [2:0]   rmd;
        logic         rvalid;
        logic         rimm;
        logic         rsh;
        logic         rjal;

        vecs[0]  = '{4'h0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd7, 32'd0, 5'd3,
                     32'd12, 5'd3};
        vecs[1]  = '{4'h3, 1'b0, 1'b1, 1'b0, 32'd99, 32'd1, 32'h80, 32'd0, 5'd4,
                     32'd4, 5'd4};
        vecs[2]  = '{4'h0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, 32'h100, 5'd0,
                     32'h104, 5'd31};
        vecs[3]  = '{4'h4, 1'b0, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0, 32'd0, 5'd7,
                     32'd7, 5'd7};
        vecs[4]  = '{4'h1, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd1,
                     32'hF000, 5'd1};
        vecs[5]  = '{4'h5, 1'b0, 1'b0, 1'b0, 32'h0F, 32'hF0, 32'd0, 32'd0, 5'd2,
                     32'hFF, 5'd2};
        vecs[6]  = '{4'h2, 1'b0, 1'b0, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'd0, 5'd9,
                     32'hF0, 5'd9};
        vecs[7]  = '{4'h6, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1234, 32'd0, 5'd8,
                     32'h1234_0000, 5'd8};
        vecs[8]  = '{4'h7, 1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'h100, 32'd0, 5'd5,
                     32'h0800_0000, 5'd5};
        vecs[9]  = '{4'hF, 1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'h100, 32'd0, 5'd6,
                     32'hF800_0000, 5'd6};
        vecs[10] = '{4'h4, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFC, 5'd5,
                     32'd0, 5'd31};

        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, MD_NONE, '0, '0, '0, '0, 5'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset estall", 64'(bus.estall), 64'd0);
        check("reset md_busy", 64'(bus.md_busy), 64'd0);
        bus.emd_op = MD_MFHI;
        #1;
        check("reset hi", 64'(bus.ealu), 64'd0);
        bus.emd_op = MD_MFLO;
        #1;
        check("reset lo", 64'(bus.ealu), 64'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            set_in(1'b1, vecs[i].aluc, vecs[i].aluimm, vecs[i].shift, vecs[i].jal, MD_NONE,
                   vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc4, vecs[i].rn0);
            #1;
            check($sformatf("vec%0d ealu", i), 64'(bus.ealu), 64'(vecs[i].exp_alu));
            check($sformatf("vec%0d ern", i), 64'(bus.ern), 64'(vecs[i].exp_rn));
            check($sformatf("vec%0d estall", i), 64'(bus.estall), 64'd0);
        end

        run_md("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_7_0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_md("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md("div_m7_0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Reset abandons a running multiply after 10 RUN cycles
        @(negedge clock);
        set_in(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0,
               '0, '0, 5'd0);
        repeat (11) @(negedge clock);
        #1;
        check("midrun estall", 64'(bus.estall), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, MD_MFHI, '0, '0, '0, '0, 5'd0);
        #1;
        m_hi = '0;
        m_lo = '0;
        check("rst_run estall", 64'(bus.estall), 64'd0);
        check("rst_run md_busy", 64'(bus.md_busy), 64'd0);
        check("rst_run hi", 64'(bus.ealu), 64'd0);
        bus.emd_op = MD_MFLO;
        #1;
        check("rst_run lo", 64'(bus.ealu), 64'd0);
        run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);

        // Invalid slot carrying a mult must not start the unit
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, MD_MULT, 32'd3, 32'd5, '0, '0, 5'd0);
            #1;
            check($sformatf("invalid%0d estall", i), 64'(bus.estall), 64'd0);
            check($sformatf("invalid%0d md_busy", i), 64'(bus.md_busy), 64'd0);
        end
        @(negedge clock);
        set_in(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, MD_MFHI, '0, '0, '0, '0, 5'd0);
        #1;
        check("invalid hi kept", 64'(bus.ealu), 64'(m_hi));
        bus.emd_op = MD_MFLO;
        #1;
        check("invalid lo kept", 64'(bus.ealu), 64'(m_lo));

        // Randomized traffic against the reference model
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rmd = 3'($urandom_range(1, 4));
                ra  = pick_operand();
                rb  = pick_operand();
                ref_md(rmd, ra, rb, eh, el);
                run_md($sformatf("rnd%0d md%0d", k, rmd), rmd, ra, rb, eh, el);
            end else begin
                rvalid = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       rmd = MD_NONE;
                    1:       rmd = MD_MFHI;
                    2:       rmd = MD_MFLO;
                    default: rmd = 3'd7;
                endcase
                if (!rvalid) rmd = 3'($urandom_range(0, 7));
                rcode = alu_codes[$urandom_range(0, 8)];
                rimm  = 1'($urandom_range(0, 1));
                rsh   = 1'($urandom_range(0, 1));
                rjal  = ($urandom_range(0, 3) == 0);
                ra    = W'($urandom);
                rb    = W'($urandom);
                ri    = W'($urandom);
                rp    = W'($urandom);
                rrn   = 5'($urandom);
                if (rjal) exp_alu = rp + 32'd4;
                else if (rmd == MD_MFHI) exp_alu = m_hi;
                else if (rmd == MD_MFLO) exp_alu = m_lo;
                else exp_alu = ref_alu(rcode, rsh ? {27'd0, ri[10:6]} : ra, rimm ? ri : rb);
                @(negedge clock);
                set_in(rvalid, rcode, rimm, rsh, rjal, rmd, ra, rb, ri, rp, rrn);
                #1;
                check($sformatf("rnd%0d ealu", k), 64'(bus.ealu), 64'(exp_alu));
                check($sformatf("rnd%0d ern", k), 64'(bus.ern), 64'(rjal ? 5'd31 : rrn));
                check($sformatf("rnd%0d estall", k), 64'(bus.estall), 64'd0);
                check($sformatf("rnd%0d md_busy", k), 64'(bus.md_busy), 64'd0);
            end
        end

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
